// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the dino game-flow controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   LIVES_W   width of the lives counter
//   state_t   state codes, also exported on the debug/LED state port
package game_ctrl_pkg;

  localparam int LIVES_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_HIT   = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

endpackage

// File: rtl/game_ctrl_pulse_timer.sv
// Saturating down-counter used for the jump pulse, overlay hold and invulnerability window.
// Latency: load/clear take effect on the next edge; busy/last decode the registered count.
// Backpressure: none; freeze holds the count in place.
//   clk, rst     clock, synchronous active-high reset
//   load         reload count to N
//   clear        force count to 0 (wins over load)
//   freeze       hold count while set
//   busy         count is non-zero
//   last         count is 1, i.e. this is the final busy cycle
module game_ctrl_pulse_timer #(
  parameter int unsigned N = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic freeze,
  output logic busy,
  output logic last
);

  localparam int W = $clog2(N + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(N);
  localparam logic [W-1:0] ONE      = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (!freeze && cnt != '0) begin
      // stops at zero rather than wrapping
      cnt <= cnt - ONE;
    end
  end

  assign busy = (cnt != '0);
  assign last = (cnt == ONE);

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: IDLE/RUN/PAUSE/HIT/OVER sequencing, start-jump pulse, overlay, lives.
// Latency: one cycle from an input edge to the corresponding output change.
// Backpressure: none; buttons are edge-qualified so a held button gives a single event.
//   clk, rst     clock, synchronous active-high reset
//   restart      start/restart button level     pause   pause button level
//   crash        collision level                show    game-over overlay enable
//   jump         start-jump pulse               running world scrolls (RUN, HIT)
//   lives_left   remaining lives                state   current state code
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned JUMP_CYCLES   = 1000,
  parameter int unsigned SHOW_CYCLES   = 50000000,
  parameter int unsigned INVULN_CYCLES = 25000000,
  parameter int unsigned LIVES         = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               pause,
  input  logic               crash,
  output logic               show,
  output logic               jump,
  output logic               running,
  output logic [LIVES_W-1:0] lives_left,
  output logic [2:0]         state
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIFE_ONE   = LIVES_W'(1);

  state_t             state_q, state_d;
  logic               restart_q, pause_q;
  logic               restart_rise, pause_rise;
  logic [LIVES_W-1:0] lives_q, lives_d;

  logic start_game, crash_run, lose_last;
  logic jump_load, jump_clear, jump_freeze, jump_busy, jump_last;
  logic show_load, show_clear, show_busy, show_last;
  logic inv_load, inv_clear, inv_busy, inv_last;
  logic unused_timer_last;

  assign restart_rise = restart & ~restart_q;
  assign pause_rise   = pause & ~pause_q;

  // State, edge-detect and lives registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      restart_q <= 1'b0;
      pause_q   <= 1'b0;
      lives_q   <= LIVES_INIT;
    end else begin
      state_q   <= state_d;
      restart_q <= restart;
      pause_q   <= pause;
      lives_q   <= lives_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (restart_rise) state_d = ST_RUN;
      ST_RUN: begin
        // crash beats a simultaneous pause
        if (crash)           state_d = (lives_q <= LIFE_ONE) ? ST_OVER : ST_HIT;
        else if (pause_rise) state_d = ST_PAUSE;
      end
      ST_PAUSE: if (pause_rise) state_d = ST_RUN;
      // leave on the last invulnerable cycle so HIT lasts exactly INVULN_CYCLES
      ST_HIT:   if (inv_last || !inv_busy) state_d = ST_RUN;
      ST_OVER:  if (restart_rise) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Timer controls, lives update and outputs
  always_comb begin
    start_game  = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && restart_rise;
    crash_run   = (state_q == ST_RUN) && crash;
    lose_last   = crash_run && (lives_q <= LIFE_ONE);

    jump_load   = start_game;
    jump_clear  = lose_last;
    jump_freeze = (state_q == ST_PAUSE);

    // overlay hold only follows a restart out of OVER, not the first start from IDLE
    show_load   = (state_q == ST_OVER) && restart_rise;
    show_clear  = lose_last;

    inv_load    = crash_run && !lose_last;
    inv_clear   = lose_last;

    lives_d = lives_q;
    if (start_game)                    lives_d = LIVES_INIT;
    else if (crash_run && lives_q != '0) lives_d = lives_q - LIFE_ONE;

    running    = (state_q == ST_RUN) || (state_q == ST_HIT);
    show       = (state_q == ST_OVER) || show_busy;
    jump       = jump_busy;
    lives_left = lives_q;
    state      = state_q;
  end

  assign unused_timer_last = jump_last ^ show_last;

  game_ctrl_pulse_timer #(.N(JUMP_CYCLES)) u_jump_tmr (
    .clk(clk), .rst(rst), .load(jump_load), .clear(jump_clear),
    .freeze(jump_freeze), .busy(jump_busy), .last(jump_last)
  );

  game_ctrl_pulse_timer #(.N(SHOW_CYCLES)) u_show_tmr (
    .clk(clk), .rst(rst), .load(show_load), .clear(show_clear),
    .freeze(1'b0), .busy(show_busy), .last(show_last)
  );

  game_ctrl_pulse_timer #(.N(INVULN_CYCLES)) u_inv_tmr (
    .clk(clk), .rst(rst), .load(inv_load), .clear(inv_clear),
    .freeze(1'b0), .busy(inv_busy), .last(inv_last)
  );

endmodule
